// File: rtl/seq_run_detect_if.sv
// Serial-bit detector bus: qualified input bit plus runtime controls in, detection status out.
// The detector takes the slave side; the feeding logic takes the master side.
interface seq_run_detect_if #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  logic             en;
  logic             w;
  logic [1:0]       mode;
  logic             overlap;
  logic             clr_cnt;
  logic             z;
  logic             z_pol;
  logic [RC_W-1:0]  run_cnt;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output en, w, mode, overlap, clr_cnt,
    input  z, z_pol, run_cnt, hit_cnt
  );

  modport slave (
    input  en, w, mode, overlap, clr_cnt,
    output z, z_pol, run_cnt, hit_cnt
  );
endinterface

// File: rtl/seq_run_detect.sv
// Run-length detector: registered Moore z one edge after the RUN_LEN-th equal accepted bit; en=0 freezes all state.
// Optional saturating hit counter with clr_cnt is built only when SEQ_RUN_HITCNT_EN is defined.
module seq_run_detect #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input logic             Clk,
  input logic             Rst_n,
  seq_run_detect_if.slave bus
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  localparam logic [RC_W-1:0] RL_MAX = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0] RL_PRE = RC_W'(RUN_LEN - 1);
  localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [RC_W-1:0] run_cnt_q, run_cnt_d;
  logic            pol_ok;
  logic            hit;

  always_comb begin
    pol_ok = 1'b0;
    case (bus.mode)
      2'b00:   pol_ok = 1'b1;
      2'b01:   pol_ok = bus.w;
      2'b10:   pol_ok = ~bus.w;
      default: pol_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    run_cnt_d = run_cnt_q;
    hit       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          last_d    = bus.w;
          run_cnt_d = RC_ONE;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.en) begin
          if (bus.w != last_q) begin
            last_d    = bus.w;
            run_cnt_d = RC_ONE;
          end else begin
            if (run_cnt_q != RL_MAX) run_cnt_d = run_cnt_q + RC_ONE;
            // Only the step onto RUN_LEN can hit; a run already saturated never does.
            if (run_cnt_q == RL_PRE && pol_ok) begin
              state_d = S_HIT;
              hit     = 1'b1;
            end
          end
        end
      end
      S_HIT: begin
        if (bus.en) begin
          if (bus.w != last_q) begin
            last_d    = bus.w;
            run_cnt_d = RC_ONE;
            state_d   = S_RUN;
          end else if (!bus.overlap) begin
            run_cnt_d = RC_ONE;
            state_d   = S_RUN;
          end else if (pol_ok) begin
            hit = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign bus.z       = (state_q == S_HIT);
  assign bus.z_pol   = last_q;
  assign bus.run_cnt = run_cnt_q;

`ifdef SEQ_RUN_HITCNT_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (bus.clr_cnt)                      hit_cnt_d = '0;
    else if (hit && (hit_cnt_q != '1))    hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign bus.hit_cnt = hit_cnt_q;
`else
  logic unused_hitcnt;
  assign unused_hitcnt = hit ^ bus.clr_cnt;
  assign bus.hit_cnt   = '0;
`endif
endmodule

// File: tb/tb_seq_run_detect.sv
// Bench for seq_run_detect: directed scenarios on a RUN_LEN=3/CNT_W=2 instance, random traffic on it and a RUN_LEN=5/CNT_W=4 instance.
module tb_seq_run_detect;
`ifdef SEQ_RUN_HITCNT_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;

  typedef struct {
    int st;
    bit last;
    int rc;
    int hc;
  } mdl_t;

  logic Clk;
  logic Rst_n;
  int   errors = 0;
  int   checks = 0;
  mdl_t ma, mb;

  seq_run_detect_if #(.RUN_LEN(3), .CNT_W(2)) ifa ();
  seq_run_detect_if #(.RUN_LEN(5), .CNT_W(4)) ifb ();

  seq_run_detect #(.RUN_LEN(3), .CNT_W(2)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ifa));
  seq_run_detect #(.RUN_LEN(5), .CNT_W(4)) dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ifb));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.st = M_IDLE; m.last = 1'b0; m.rc = 0; m.hc = 0;
    return m;
  endfunction

  // Reference: follows the run of equal accepted bits and decides hits from the run length and polarity rules.
  function automatic mdl_t mdl_next(mdl_t m, int rl, int cw, bit e, bit wv,
                                    logic [1:0] md, bit ov, bit clr);
    mdl_t n;
    bit   pol;
    bit   hit;
    n   = m;
    hit = 1'b0;
    pol = (md == 2'b00) || (md == 2'b01 && wv) || (md == 2'b10 && !wv);
    if (e) begin
      if (m.st == M_IDLE || wv != m.last) begin
        n.st = M_RUN; n.last = wv; n.rc = 1;
      end else if (m.st == M_RUN) begin
        if (m.rc < rl) n.rc = m.rc + 1;
        if (m.rc == rl - 1 && pol) begin n.st = M_HIT; hit = 1'b1; end
      end else if (!ov) begin
        n.st = M_RUN; n.rc = 1;
      end else if (pol) begin
        hit = 1'b1;
      end else begin
        n.st = M_RUN;
      end
    end
    if (HC_EN) begin
      if (clr) n.hc = 0;
      else if (hit && n.hc < (1 << cw) - 1) n.hc = n.hc + 1;
    end
    return n;
  endfunction

  task automatic step(input bit e, input bit wv, input logic [1:0] md, input bit ov, input bit clr);
    ifa.en = e; ifa.w = wv; ifa.mode = md; ifa.overlap = ov; ifa.clr_cnt = clr;
    ifb.en = e; ifb.w = wv; ifb.mode = md; ifb.overlap = ov; ifb.clr_cnt = clr;
    @(posedge Clk);
    ma = mdl_next(ma, 3, 2, e, wv, md, ov, clr);
    mb = mdl_next(mb, 5, 4, e, wv, md, ov, clr);
    #2;
  endtask

  task automatic do_reset();
    step_idle();
    Rst_n = 1'b0;
    #1;
    ma = mdl_init();
    mb = mdl_init();
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
  endtask

  task automatic step_idle();
    ifa.en = 1'b0; ifa.w = 1'b0; ifa.mode = 2'b00; ifa.overlap = 1'b0; ifa.clr_cnt = 1'b0;
    ifb.en = 1'b0; ifb.w = 1'b0; ifb.mode = 2'b00; ifb.overlap = 1'b0; ifb.clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (ifa.z !== 1'b0)        begin errors++; $display("FAIL reset_z: got %b expected 0", ifa.z); end
    if (ifa.z_pol !== 1'b0)    begin errors++; $display("FAIL reset_z_pol: got %b expected 0", ifa.z_pol); end
    if (ifa.run_cnt !== 2'd0)  begin errors++; $display("FAIL reset_run_cnt: got %0d expected 0", ifa.run_cnt); end
    if (ifa.hit_cnt !== 2'd0)  begin errors++; $display("FAIL reset_hit_cnt: got %0d expected 0", ifa.hit_cnt); end
    // Build a hit, then drop reset between edges.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    #1;
    Rst_n = 1'b0;
    #1;
    ma = mdl_init();
    mb = mdl_init();
    checks += 4;
    if (ifa.z !== 1'b0)        begin errors++; $display("FAIL midrun_reset_z: got %b expected 0", ifa.z); end
    if (ifa.run_cnt !== 2'd0)  begin errors++; $display("FAIL midrun_reset_run_cnt: got %0d expected 0", ifa.run_cnt); end
    if (ifa.hit_cnt !== 2'd0)  begin errors++; $display("FAIL midrun_reset_hit_cnt: got %0d expected 0", ifa.hit_cnt); end
    if (ifb.run_cnt !== 3'd0)  begin errors++; $display("FAIL midrun_reset_run_cnt_b: got %0d expected 0", ifb.run_cnt); end
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    checks += 2;
    if (ifa.run_cnt !== 2'd1)  begin errors++; $display("FAIL post_reset_run_cnt: got %0d expected 1", ifa.run_cnt); end
    if (ifa.z_pol !== 1'b1)    begin errors++; $display("FAIL post_reset_z_pol: got %b expected 1", ifa.z_pol); end
  endtask

  task automatic test_overlap();
    bit w_seq [5] = '{0, 0, 0, 0, 1};
    bit z_exp [5] = '{0, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, w_seq[i], 2'b00, 1'b1, 1'b0);
      checks++;
      if (ifa.z !== z_exp[i]) begin errors++; $display("FAIL overlap_z[%0d]: got %b expected %b", i, ifa.z, z_exp[i]); end
      if (z_exp[i]) begin
        checks++;
        if (ifa.z_pol !== 1'b0) begin errors++; $display("FAIL overlap_z_pol[%0d]: got %b expected 0", i, ifa.z_pol); end
      end
    end
    checks++;
    if (ifa.hit_cnt !== (HC_EN ? 2'd2 : 2'd0))
      begin errors++; $display("FAIL overlap_hit_cnt: got %0d expected %0d", ifa.hit_cnt, HC_EN ? 2 : 0); end
  endtask

  task automatic test_nonoverlap();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      checks++;
      if (ifa.z !== ((i == 3) || (i == 6)))
        begin errors++; $display("FAIL nonoverlap_z[%0d]: got %b expected %b", i, ifa.z, (i == 3) || (i == 6)); end
    end
    checks += 2;
    if (ifa.hit_cnt !== (HC_EN ? 2'd2 : 2'd0))
      begin errors++; $display("FAIL nonoverlap_hit_cnt: got %0d expected %0d", ifa.hit_cnt, HC_EN ? 2 : 0); end
    if (ifa.run_cnt !== 2'd1)
      begin errors++; $display("FAIL nonoverlap_run_cnt: got %0d expected 1", ifa.run_cnt); end
  endtask

  task automatic test_polarity();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    checks += 2;
    if (ifa.z !== 1'b0)       begin errors++; $display("FAIL pol_zeros_z: got %b expected 0", ifa.z); end
    if (ifa.run_cnt !== 2'd3) begin errors++; $display("FAIL pol_zeros_run_cnt: got %0d expected 3", ifa.run_cnt); end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
    checks += 2;
    if (ifa.z !== 1'b1)       begin errors++; $display("FAIL pol_ones_z: got %b expected 1", ifa.z); end
    if (ifa.hit_cnt !== (HC_EN ? 2'd1 : 2'd0))
      begin errors++; $display("FAIL pol_hit_cnt: got %0d expected %0d", ifa.hit_cnt, HC_EN ? 1 : 0); end
  endtask

  task automatic test_en_gating();
    do_reset();
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checks += 2;
    if (ifa.run_cnt !== 2'd2) begin errors++; $display("FAIL gate_hold_run_cnt: got %0d expected 2", ifa.run_cnt); end
    if (ifa.z !== 1'b0)       begin errors++; $display("FAIL gate_hold_z: got %b expected 0", ifa.z); end
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    checks++;
    if (ifa.z !== 1'b1)       begin errors++; $display("FAIL gate_z: got %b expected 1", ifa.z); end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checks++;
    if (ifa.z !== 1'b1)       begin errors++; $display("FAIL gate_z_held: got %b expected 1", ifa.z); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    checks += 2;
    if (ifa.hit_cnt !== (HC_EN ? 2'd3 : 2'd0))
      begin errors++; $display("FAIL sat_hit_cnt: got %0d expected %0d", ifa.hit_cnt, HC_EN ? 3 : 0); end
    if (ifb.hit_cnt !== (HC_EN ? 4'd6 : 4'd0))
      begin errors++; $display("FAIL sat_hit_cnt_b: got %0d expected %0d", ifb.hit_cnt, HC_EN ? 6 : 0); end
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    checks += 2;
    if (ifa.hit_cnt !== 2'd0) begin errors++; $display("FAIL clr_with_hit: got %0d expected 0", ifa.hit_cnt); end
    if (ifa.z !== 1'b1)       begin errors++; $display("FAIL clr_z: got %b expected 1", ifa.z); end
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    checks++;
    if (ifa.hit_cnt !== (HC_EN ? 2'd1 : 2'd0))
      begin errors++; $display("FAIL after_clr_hit_cnt: got %0d expected %0d", ifa.hit_cnt, HC_EN ? 1 : 0); end
  endtask

  task automatic test_random();
    bit         e, wv, ov, clr;
    logic [1:0] md;
    do_reset();
    wv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      e   = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) wv = ~wv;
      md  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      ov  = $urandom_range(0, 1);
      clr = e && ($urandom_range(0, 19) == 0);
      step(e, wv, md, ov, clr);
      checks += 8;
      if (ifa.z !== (ma.st == M_HIT))  begin errors++; $display("FAIL rnd_a_z@%0d: got %b expected %b", i, ifa.z, ma.st == M_HIT); end
      if (ifa.z_pol !== ma.last)       begin errors++; $display("FAIL rnd_a_z_pol@%0d: got %b expected %b", i, ifa.z_pol, ma.last); end
      if (ifa.run_cnt !== 2'(ma.rc))   begin errors++; $display("FAIL rnd_a_run_cnt@%0d: got %0d expected %0d", i, ifa.run_cnt, ma.rc); end
      if (ifa.hit_cnt !== 2'(ma.hc))   begin errors++; $display("FAIL rnd_a_hit_cnt@%0d: got %0d expected %0d", i, ifa.hit_cnt, ma.hc); end
      if (ifb.z !== (mb.st == M_HIT))  begin errors++; $display("FAIL rnd_b_z@%0d: got %b expected %b", i, ifb.z, mb.st == M_HIT); end
      if (ifb.z_pol !== mb.last)       begin errors++; $display("FAIL rnd_b_z_pol@%0d: got %b expected %b", i, ifb.z_pol, mb.last); end
      if (ifb.run_cnt !== 3'(mb.rc))   begin errors++; $display("FAIL rnd_b_run_cnt@%0d: got %0d expected %0d", i, ifb.run_cnt, mb.rc); end
      if (ifb.hit_cnt !== 4'(mb.hc))   begin errors++; $display("FAIL rnd_b_hit_cnt@%0d: got %0d expected %0d", i, ifb.hit_cnt, mb.hc); end
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    ma = mdl_init();
    mb = mdl_init();
    step_idle();
    #3;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_polarity();
    test_en_gating();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
